// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the IM write port.
// Define IM_LOADER_CKSUM_EN to include the trailing XOR checksum byte.
package im_loader_pkg;

    localparam int unsigned IM_DEPTH = 1024;
    localparam int unsigned IM_AW    = 10;
    localparam int unsigned LEN_W    = 11;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned WORD_W   = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
`ifdef IM_LOADER_CKSUM_EN
        CKSUM = 3'd3,
`endif
        DONE  = 3'd4
    } state_t;

    // Requested word counts beyond the memory depth clamp to a full load.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(IM_DEPTH)) ? LEN_W'(IM_DEPTH) : len;
    endfunction

endpackage

// File: rtl/im_loader_byte_packer.sv
// Big-endian byte-to-word assembler: 2-bit byte counter plus 32-bit shift register.
module byte_packer
    import im_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] din,
    output logic              last_c,
    output logic [WORD_W-1:0] word
);

    logic [1:0] cnt;

    // Earlier bytes move toward the MSB, so the first byte ends in [31:24].
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            word <= '0;
        end else if (clr) begin
            cnt  <= '0;
        end else if (shift_en) begin
            cnt  <= cnt + 2'd1;
            word <= {word[WORD_W-BYTE_W-1:0], din};
        end
    end

    assign last_c = (cnt == 2'd3);

endmodule

// File: rtl/im_loader.sv
// Streams program bytes into instruction memory, one 32-bit word per write.
// Define IM_LOADER_CKSUM_EN to expect and verify a trailing XOR checksum byte.
module im_loader
    import im_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [IM_AW-1:0]  im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              busy,
    output logic              done,
    output logic              cksum_err
);

    state_t           state, state_d;
    logic [LEN_W-1:0] len_q, len_d, wcnt, wcnt_d, wnext;
    logic [IM_AW-1:0] addr_d;
    logic             we_d, ready_d, busy_d, done_d;
    logic             accept, pk_clr, pk_shift, pk_last;

    assign accept   = byte_valid && byte_ready;
    assign pk_shift = accept && (state == RECV);
    assign wnext    = wcnt + LEN_W'(1);

`ifdef IM_LOADER_CKSUM_EN
    logic [BYTE_W-1:0] xor_q, xor_d;
    logic              err_d;
`endif

    byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clr      (pk_clr),
        .shift_en (pk_shift),
        .din      (byte_data),
        .last_c   (pk_last),
        .word     (im_wdata)
    );

    // Next-state and next-output computation; all outputs are registered below.
    always_comb begin
        state_d = state;
        len_d   = len_q;
        wcnt_d  = wcnt;
        addr_d  = im_addr;
        we_d    = 1'b0;
        pk_clr  = 1'b0;
`ifdef IM_LOADER_CKSUM_EN
        xor_d   = xor_q;
        err_d   = cksum_err;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    len_d  = sat_len(load_len);
                    wcnt_d = '0;
                    pk_clr = 1'b1;
`ifdef IM_LOADER_CKSUM_EN
                    xor_d  = '0;
                    err_d  = 1'b0;
`endif
                    state_d = (sat_len(load_len) == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (accept) begin
`ifdef IM_LOADER_CKSUM_EN
                    xor_d = xor_q ^ byte_data;
`endif
                    if (pk_last) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        addr_d  = wcnt[IM_AW-1:0];
                    end
                end
            end
            WRITE: begin
                wcnt_d = wnext;
                if (wnext == len_q) begin
`ifdef IM_LOADER_CKSUM_EN
                    state_d = CKSUM;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = RECV;
                end
            end
`ifdef IM_LOADER_CKSUM_EN
            CKSUM: begin
                if (accept) begin
                    err_d   = (byte_data != xor_q);
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == RECV);
        busy_d  = (state_d == RECV) || (state_d == WRITE);
`ifdef IM_LOADER_CKSUM_EN
        ready_d = ready_d || (state_d == CKSUM);
        busy_d  = busy_d  || (state_d == CKSUM);
`endif
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            len_q      <= '0;
            wcnt       <= '0;
            im_addr    <= '0;
            im_we      <= 1'b0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            len_q      <= len_d;
            wcnt       <= wcnt_d;
            im_addr    <= addr_d;
            im_we      <= we_d;
            byte_ready <= ready_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

`ifdef IM_LOADER_CKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xor_q     <= '0;
            cksum_err <= 1'b0;
        end else begin
            xor_q     <= xor_d;
            cksum_err <= err_d;
        end
    end
`else
    assign cksum_err = 1'b0;
`endif

endmodule
